// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, the hardwired-zero register
// and the write-arbiter state type.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward modulo N. Shared by the read- and write-port arbiters.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ requesters; all write-port outputs are registered.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW,
  parameter bit DROP0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               busy
);

  localparam int PW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // A requester just acked still holds req this cycle; mask it so it is not regranted.
  always_comb begin
    eligible = req;
    if (state_q == WRITE) begin
      eligible = req & ~ack_q;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    win_addr = req_addr[int'(win_idx)*AW +: AW];
    win_data = req_data[int'(win_idx)*DW +: DW];
  end

  always_comb begin
    state_d   = IDLE;
    ptr_d     = ptr_q;
    ack_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (win_valid) begin
      state_d   = WRITE;
      ack_d     = grant;
      wr_addr_d = win_addr;
      wr_data_d = win_data;
      // Register 0 is hardwired to zero: retire the request without writing.
      wr_en_d   = !(DROP0 && (win_addr == AW'(REG_ZERO)));
      if (win_idx == PW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ack     = ack_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = wr_en_q | (|req);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: behavioural model compared
// every cycle, directed literal scenarios, then randomized requester traffic.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  regfile_write_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .AW    (AW),
    .DROP0 (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who retires next is the first requester at or after the
  // rotating pointer, skipping whoever was retired in the previous cycle.
  int               m_ptr;
  int               m_last;
  logic             m_wr_en;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  logic [NREQ-1:0]  m_ack;

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    int i;
    if (!rst_n) begin
      m_ptr = 0; m_last = -1; m_wr_en = 1'b0;
      m_addr = '0; m_data = '0; m_ack = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (w < 0 && req[i] && i != m_last) w = i;
      end
      if (w >= 0) begin
        m_addr  = req_addr[w*AW +: AW];
        m_data  = req_data[w*DW +: DW];
        m_wr_en = (m_addr != 0);
        m_ack   = '0;
        m_ack[w] = 1'b1;
        m_last  = w;
        m_ptr   = (w + 1) % NREQ;
      end else begin
        m_wr_en = 1'b0;
        m_ack   = '0;
        m_last  = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ack",     64'(ack),     64'(m_ack));
      check("model_wr_en",   64'(wr_en),   64'(m_wr_en));
      check("model_wr_addr", 64'(wr_addr), 64'(m_addr));
      check("model_wr_data", 64'(wr_data), 64'(m_data));
      check("model_busy",    64'(busy),    64'(m_wr_en | (|req)));
      check("ack_onehot0",   64'($onehot0(ack)), 64'(1));
      if (wr_en) check("ack_with_wr_en", 64'($onehot(ack)), 64'(1));
    end
  end

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    req   = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] exp_ack;

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_wr_en",   64'(wr_en),   64'(0));
      check("idle_ack",     64'(ack),     64'(0));
      check("idle_busy",    64'(busy),    64'(0));
      check("idle_wr_addr", 64'(wr_addr), 64'(0));
      check("idle_wr_data", 64'(wr_data), 64'(0));
    end

    // Single request, then pointer at 3 favours req[3] over req[0], then wrap
    #1 set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
    @(negedge clk);
    check("single_wr_en",   64'(wr_en),   64'(1));
    check("single_wr_addr", 64'(wr_addr), 64'(7));
    check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    check("single_ack",     64'(ack),     64'(4'b0100));
    #1 req[2] = 1'b0;
    set_req(0, 1'b1, 5'd10, 32'h0000_0A0A);
    set_req(3, 1'b1, 5'd9,  32'h0000_0909);
    @(negedge clk);
    check("ptr3_ack",  64'(ack),     64'(4'b1000));
    check("ptr3_addr", 64'(wr_addr), 64'(9));
    #1 req[3] = 1'b0;
    @(negedge clk);
    check("wrap_ack",  64'(ack),     64'(4'b0001));
    check("wrap_addr", 64'(wr_addr), 64'(10));

    // All four request at once, each drops on its ack
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h1000 + i));
    for (int c = 0; c < NREQ; c++) begin
      @(negedge clk);
      exp_ack = '0;
      exp_ack[c] = 1'b1;
      check("all_ack",   64'(ack),     64'(exp_ack));
      check("all_wr_en", 64'(wr_en),   64'(1));
      check("all_addr",  64'(wr_addr), 64'(c + 1));
      #1 req[c] = 1'b0;
    end
    @(negedge clk);
    check("all_done_wr_en", 64'(wr_en), 64'(0));

    // Write to register 0 is acked but suppressed
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h1234_5678);
    @(negedge clk);
    check("zero_ack",   64'(ack),   64'(4'b0010));
    check("zero_wr_en", 64'(wr_en), 64'(0));
    #1 req[1] = 1'b0;

    // Lone requester held: at most one write every other cycle
    do_reset();
    set_req(3, 1'b1, 5'd12, 32'hCAFE_0003);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("lone_ack", 64'(ack), (c % 2 == 1) ? 64'(4'b1000) : 64'(0));
    end
    #1 req[3] = 1'b0;

    // Reset mid-write aborts the write; pointer back at 0 afterwards
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hAAAA_0000);
    set_req(1, 1'b1, 5'd2, 32'hBBBB_1111);
    @(negedge clk);
    check("midrst_pre_ack",   64'(ack),   64'(4'b0001));
    check("midrst_pre_wr_en", 64'(wr_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 64'(wr_en), 64'(0));
    check("midrst_ack",   64'(ack),   64'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ack",  64'(ack),     64'(4'b0001));
    check("postrst_addr", 64'(wr_addr), 64'(1));

    // Randomized traffic; requesters follow the hold-until-ack protocol
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else set_req(i, 1'b1, ($urandom_range(7, 0) == 0) ? AW'(0) : AW'($urandom_range(31, 0)), $urandom);
        end else if (!req[i] && $urandom_range(9, 0) < 4) begin
          set_req(i, 1'b1, ($urandom_range(7, 0) == 0) ? AW'(0) : AW'($urandom_range(31, 0)), $urandom);
        end
      end
    end
    step();
    req = '0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
